// File: rtl/muldiv_sequencer.sv
// Iterative unsigned multiply / divide unit: one shift-add or restoring-divide
// step per clock, DATA_WIDTH steps per operation, single-cycle done pulse.
module muldiv_sequencer #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start_i,
  input  logic [1:0]            op_i,
  input  logic [DATA_WIDTH-1:0] rs1_i,
  input  logic [DATA_WIDTH-1:0] rs2_i,
  input  logic                  flush_i,
  output logic                  busy_o,
  output logic                  done_o,
  output logic [DATA_WIDTH-1:0] result_o
);

  localparam int N  = DATA_WIDTH;
  localparam int CW = $clog2(N + 1);
  localparam logic [CW-1:0] LAST_ITER = CW'(N - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t          r_state;
  logic [1:0]      r_op;
  logic [N-1:0]    r_b;
  logic [N-1:0]    r_hi;
  logic [N-1:0]    r_lo;
  logic [CW-1:0]   r_cnt;
  logic            r_divzero;
  logic            r_done;
  logic [N-1:0]    r_result;

  logic [N:0]      w_mul_sum;
  logic [N:0]      w_div_shift;
  logic [N:0]      w_div_diff;
  logic            w_qbit;
  logic [N-1:0]    w_hi_next;
  logic [N-1:0]    w_lo_next;
  logic [N-1:0]    w_final;

  // Multiply: hi accumulates, lo holds the multiplier shifting out LSB-first.
  // Divide: hi is the partial remainder, lo shifts dividend out / quotient in.
  assign w_mul_sum   = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_b} : {(N+1){1'b0}});
  assign w_div_shift = {r_hi, r_lo[N-1]};
  assign w_div_diff  = w_div_shift - {1'b0, r_b};
  assign w_qbit      = ~w_div_diff[N];

  always_comb begin
    w_hi_next = r_hi;
    w_lo_next = r_lo;
    if (r_op[1]) begin
      w_hi_next = w_qbit ? w_div_diff[N-1:0] : w_div_shift[N-1:0];
      w_lo_next = {r_lo[N-2:0], w_qbit};
    end else begin
      w_hi_next = w_mul_sum[N:1];
      w_lo_next = {w_mul_sum[0], r_lo[N-1:1]};
    end
  end

  // op[0] selects the high half (MULHU / REMU); divide-by-zero bypasses the datapath.
  always_comb begin
    w_final = r_op[0] ? w_hi_next : w_lo_next;
    if (r_divzero) begin
      w_final = r_op[0] ? r_lo : {N{1'b1}};
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state   <= S_IDLE;
      r_op      <= 2'b00;
      r_b       <= '0;
      r_hi      <= '0;
      r_lo      <= '0;
      r_cnt     <= '0;
      r_divzero <= 1'b0;
      r_done    <= 1'b0;
      r_result  <= '0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start_i && !flush_i) begin
            r_op      <= op_i;
            r_b       <= op_i[1] ? rs2_i : rs1_i;
            r_hi      <= '0;
            r_lo      <= op_i[1] ? rs1_i : rs2_i;
            r_cnt     <= '0;
            r_divzero <= op_i[1] && (rs2_i == '0);
            r_state   <= S_RUN;
          end
        end
        S_RUN: begin
          if (flush_i) begin
            r_state <= S_IDLE;
          end else if (r_divzero) begin
            r_result <= w_final;
            r_done   <= 1'b1;
            r_state  <= S_DONE;
          end else begin
            r_hi  <= w_hi_next;
            r_lo  <= w_lo_next;
            r_cnt <= r_cnt + CW'(1);
            if (r_cnt == LAST_ITER) begin
              r_result <= w_final;
              r_done   <= 1'b1;
              r_state  <= S_DONE;
            end
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign busy_o   = (r_state != S_IDLE);
  assign done_o   = r_done;
  assign result_o = r_result;

endmodule
